// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register with a valid/ready handshake.
// State and registered handshake outputs update on the falling edge of clk.
module pipe_skid_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] skid;
    logic             in_fire;
    logic             out_fire;

    // Fire terms use only registered handshake outputs, so no comb path in->out.
    always_comb begin
        in_fire  = in_valid & in_ready;
        out_fire = out_valid & out_ready;
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            count     <= 2'd0;
            out_data  <= '0;
            skid      <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            count     <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        out_data  <= in_data;
                        state     <= BUSY;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b1;
                        count     <= 2'd1;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        out_data <= in_data;
                    end else if (in_fire) begin
                        skid     <= in_data;
                        state    <= FULL;
                        in_ready <= 1'b0;
                        count    <= 2'd2;
                    end else if (out_fire) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        count     <= 2'd0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        out_data <= skid;
                        state    <= BUSY;
                        in_ready <= 1'b1;
                        count    <= 2'd1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    count     <= 2'd0;
                end
            endcase
        end
    end

endmodule
